// File: rtl/tx_fire_controller.sv
// Burst sequencer for the transducer channel bank: owns the shared time base, the 2-bit
// command bus and the per-channel phase/charge table. Define TXCTL_WATCHDOG_EN to bound FIRE.
module tx_fire_controller #(
  parameter int unsigned NCH = 8,
  parameter int unsigned AW  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               clearErr,
  input  logic [15:0]        numFires,
  input  logic [31:0]        priCycles,
  input  logic               tblWe,
  input  logic [AW-1:0]      tblAddr,
  input  logic [31:0]        tblData,
  output logic [1:0]         txCmd,
  output logic [31:0]        txCntr,
  output logic [NCH*32-1:0]  txPhaseCharge,
  input  logic [NCH-1:0]     txIsActive,
  input  logic [NCH-1:0]     txErrorFlag,
  output logic               busy,
  output logic               done,
  output logic [15:0]        fireCount,
  output logic               errorOut,
  output logic [NCH-1:0]     errorMask
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_FIRE, S_GAP, S_ERROR, S_CLR} state_t;

  localparam logic [1:0] CMD_WAIT = 2'b00;
  localparam logic [1:0] CMD_FIRE = 2'b10;
  localparam logic [1:0] CMD_RST  = 2'b11;
`ifdef TXCTL_WATCHDOG_EN
  localparam logic [31:0] WDOG_LIMIT = 32'd66050;
`endif

  state_t                state;
  logic [15:0]           num_fires_q;
  logic [31:0]           pri_cycles_q;
  logic [31:0]           pri_cntr;
  logic [NCH-1:0][31:0]  tbl;
  logic                  pri_expired;
  logic                  fire_idle;
  logic                  any_err;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign txPhaseCharge = tbl;
  assign any_err       = |txErrorFlag;
  assign fire_idle     = (txCntr >= 32'd2) && (txIsActive == '0);
  // 33-bit compare so a saturated priCntr cannot wrap past priCycles.
  assign pri_expired   = ({1'b0, pri_cntr} + 33'd1) >= {1'b0, pri_cycles_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      txCmd        <= CMD_WAIT;
      txCntr       <= '0;
      pri_cntr     <= '0;
      num_fires_q  <= '0;
      pri_cycles_q <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fireCount    <= '0;
      errorOut     <= 1'b0;
      errorMask    <= '0;
      tbl          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          txCmd  <= CMD_WAIT;
          txCntr <= '0;
          if (tblWe && (32'(tblAddr) < NCH))
            tbl[tblAddr] <= tblData;
          if (start && !abort) begin
            num_fires_q  <= numFires;
            pri_cycles_q <= priCycles;
            fireCount    <= '0;
            busy         <= 1'b1;
            state        <= S_ARM;
          end
        end

        S_ARM: begin
          if (any_err) begin
            state     <= S_ERROR;
            txCmd     <= CMD_WAIT;
            errorOut  <= 1'b1;
            errorMask <= errorMask | txErrorFlag;
          end else if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (num_fires_q == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= S_FIRE;
            txCmd    <= CMD_FIRE;
            txCntr   <= '0;
            pri_cntr <= '0;
          end
        end

        S_FIRE: begin
          if (any_err) begin
            state     <= S_ERROR;
            txCmd     <= CMD_WAIT;
            errorOut  <= 1'b1;
            errorMask <= errorMask | txErrorFlag;
          end
`ifdef TXCTL_WATCHDOG_EN
          else if ((txCntr >= WDOG_LIMIT) && (|txIsActive)) begin
            state     <= S_ERROR;
            txCmd     <= CMD_WAIT;
            errorOut  <= 1'b1;
            errorMask <= txIsActive;
          end
`endif
          else if (abort) begin
            state  <= S_IDLE;
            txCmd  <= CMD_WAIT;
            txCntr <= '0;
            busy   <= 1'b0;
          end else if (fire_idle) begin
            state     <= S_GAP;
            txCmd     <= CMD_WAIT;
            fireCount <= fireCount + 16'd1;
            pri_cntr  <= sat_inc(pri_cntr);
          end else begin
            txCntr   <= sat_inc(txCntr);
            pri_cntr <= sat_inc(pri_cntr);
          end
        end

        S_GAP: begin
          if (any_err) begin
            state     <= S_ERROR;
            txCmd     <= CMD_WAIT;
            errorOut  <= 1'b1;
            errorMask <= errorMask | txErrorFlag;
          end else if (abort) begin
            state  <= S_IDLE;
            txCntr <= '0;
            busy   <= 1'b0;
          end else if (pri_expired) begin
            if (fireCount == num_fires_q) begin
              state  <= S_IDLE;
              txCntr <= '0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              state    <= S_FIRE;
              txCmd    <= CMD_FIRE;
              txCntr   <= '0;
              pri_cntr <= '0;
            end
          end else begin
            pri_cntr <= sat_inc(pri_cntr);
          end
        end

        S_ERROR: begin
          txCmd     <= CMD_WAIT;
          errorMask <= errorMask | txErrorFlag;
          if (clearErr) begin
            state <= S_CLR;
            txCmd <= CMD_RST;
          end
        end

        S_CLR: begin
          state     <= S_IDLE;
          txCmd     <= CMD_WAIT;
          txCntr    <= '0;
          errorOut  <= 1'b0;
          errorMask <= '0;
          busy      <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          txCmd <= CMD_WAIT;
        end
      endcase
    end
  end

endmodule
